alu_cc_pipe: RTL and testbench

- Parametrised, registered successor to the 64-bit combinational ALU: same four functions (add, sub, and, xor) at any data width.
- Adds a valid/ready handshake, a one-stage output register and a Y86 condition-code register (ZF/SF/OF).
- Adds a combinational condition evaluator (cnd) for jXX/cmovXX, driven from the stored flags.
- Sits in the execute stage between operand select and the memory/write-back path.

---
 rtl/alu_cc_pipe.sv | 65 ++++++
 tb/tb_alu_cc_pipe.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/alu_cc_pipe.sv
// alu_cc_pipe: registered add/sub/and/xor ALU with valid/ready handshake, Y86 ZF/SF/OF register and cnd evaluator
module alu_cc_pipe #(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       fn,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic [2:0]       cc,
  input  logic [3:0]       cond_fn,
  output logic             cnd
);
  localparam int MSB = WIDTH - 1;
  logic             out_valid_q, out_valid_d, carry_q, carry_d, accept;
  logic [WIDTH-1:0] result_q, result_d, r_w;
  logic [2:0]       cc_q, cc_d;
  logic [WIDTH:0]   add_w, sub_w;
  logic             c_w, of_w, lt, zf;
  assign in_ready = !out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  // the extra top bit of the difference is the borrow, i.e. a <u b
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  always_comb begin
    r_w  = fn == 2'b00 ? add_w[MSB:0] : fn == 2'b01 ? sub_w[MSB:0] : fn == 2'b10 ? a & b : a ^ b;
    c_w  = fn == 2'b00 ? add_w[WIDTH] : fn == 2'b01 ? sub_w[WIDTH] : 1'b0;
    of_w = fn == 2'b00 ? (a[MSB] == b[MSB]) & (r_w[MSB] != a[MSB]) :
           fn == 2'b01 ? (a[MSB] != b[MSB]) & (r_w[MSB] != a[MSB]) : 1'b0;
    out_valid_d = accept | (out_valid_q & !out_ready);
    result_d    = accept ? r_w : result_q;
    carry_d     = accept ? c_w : carry_q;
    cc_d        = accept & set_cc ? {r_w == '0, r_w[MSB], of_w} : cc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      cc_q        <= CC_RESET;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      cc_q        <= cc_d;
    end
  end
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign cc        = cc_q;
  assign zf        = cc_q[2];
  assign lt        = cc_q[1] ^ cc_q[0];
  assign cnd = cond_fn == 4'd0 ? 1'b1 : cond_fn == 4'd1 ? lt | zf : cond_fn == 4'd2 ? lt :
               cond_fn == 4'd3 ? zf : cond_fn == 4'd4 ? !zf : cond_fn == 4'd5 ? !lt :
               cond_fn == 4'd6 ? !lt & !zf : 1'b0;
endmodule

// File: tb/tb_alu_cc_pipe.sv
// tb_alu_cc_pipe: directed table-driven bench for alu_cc_pipe at WIDTH=64 plus a WIDTH=8 instance
module tb_alu_cc_pipe;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, out_ready = 1, set_cc = 0;
  logic [63:0] a = 0, b = 0;
  logic [1:0]  fn = 0;
  logic [3:0]  cond_fn = 0;
  logic        in_ready, out_valid, carry, cnd;
  logic [63:0] result;
  logic [2:0]  cc;
  logic        in_valid8 = 0, set_cc8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [1:0]  fn8 = 0;
  logic        in_ready8, out_valid8, carry8, cnd8;
  logic [7:0]  result8;
  logic [2:0]  cc8;
  int          n_chk = 0, n_pass = 0;

  alu_cc_pipe #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .fn(fn),
    .set_cc(set_cc), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .cc(cc), .cond_fn(cond_fn), .cnd(cnd));

  alu_cc_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8), .fn(fn8),
    .set_cc(set_cc8), .out_valid(out_valid8), .out_ready(out_ready), .result(result8),
    .carry(carry8), .cc(cc8), .cond_fn(cond_fn), .cnd(cnd8));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a, b;
    logic [1:0]  fn;
    logic        sc;
    logic [3:0]  cf;
    logic [63:0] r;
    logic        c;
    logic [2:0]  cc;
    logic        cnd;
  } vec_t;
  vec_t v[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    v[0] = '{64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b1, 4'd6, 64'd1, 1'b1, 3'b000, 1'b1};
    v[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b1, 4'd2, 64'h8000_0000_0000_0000, 1'b0, 3'b011, 1'b0};
    v[2] = '{64'd5, 64'd5, 2'b01, 1'b1, 4'd3, 64'd0, 1'b0, 3'b100, 1'b1};
    v[3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 2'b00, 1'b0, 4'd4, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3'b100, 1'b0};
    v[4] = '{64'hF0, 64'h3C, 2'b10, 1'b1, 4'd1, 64'h30, 1'b0, 3'b000, 1'b0};
    v[5] = '{64'hF0, 64'hFF, 2'b11, 1'b1, 4'd0, 64'h0F, 1'b0, 3'b000, 1'b1};
    v[6] = '{64'd0, 64'd1, 2'b01, 1'b1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'b010, 1'b1};
    v[7] = '{64'h8000_0000_0000_0000, 64'd1, 2'b01, 1'b1, 4'd9, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b001, 1'b0};

    tick; tick;
    rst = 0;
    cond_fn = 4'd3;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst result", result, 0);
    chk("rst carry", carry, 0);
    chk("rst cc", cc, 3'b100);
    chk("rst in_ready", in_ready, 1);
    chk("rst cnd e", cnd, 1);

    // back-to-back stream, one accept per cycle
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; a = v[i].a; b = v[i].b; fn = v[i].fn; set_cc = v[i].sc; cond_fn = v[i].cf;
      tick;
      chk($sformatf("v%0d in_ready", i), in_ready, 1);
      chk($sformatf("v%0d out_valid", i), out_valid, 1);
      chk($sformatf("v%0d result", i), result, v[i].r);
      chk($sformatf("v%0d carry", i), carry, v[i].c);
      chk($sformatf("v%0d cc", i), cc, v[i].cc);
      chk($sformatf("v%0d cnd", i), cnd, v[i].cnd);
    end
    in_valid = 0; a = 'x; b = 'x; fn = 'x; set_cc = 0;
    tick;
    chk("drain out_valid", out_valid, 0);
    chk("drain result hold", result, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("drain cc hold", cc, 3'b001);
    cond_fn = 4'd5; #1;
    chk("cc001 ge", cnd, 0);

    // backpressure: xor then a stalled and
    out_ready = 0;
    in_valid = 1; a = 64'hF0; b = 64'hFF; fn = 2'b11; set_cc = 1;
    tick;
    chk("bp xor result", result, 64'h0F);
    chk("bp in_ready low", in_ready, 0);
    chk("bp cc", cc, 3'b000);
    a = 64'hF0; b = 64'h3C; fn = 2'b10; set_cc = 0;
    tick;
    chk("bp stall result", result, 64'h0F);
    chk("bp stall out_valid", out_valid, 1);
    out_ready = 1; #1;
    chk("bp in_ready comb", in_ready, 1);
    tick;
    chk("bp swap result", result, 64'h30);
    chk("bp swap out_valid", out_valid, 1);
    in_valid = 0;
    tick;
    chk("bp consumed", out_valid, 0);
    chk("bp hold result", result, 64'h30);

    // reset while a result is held
    out_ready = 0;
    in_valid = 1; a = 64'd7; b = 64'd1; fn = 2'b00; set_cc = 1;
    tick;
    chk("pre-rst out_valid", out_valid, 1);
    in_valid = 0; rst = 1;
    tick;
    rst = 0; out_ready = 1; #1;
    chk("mid-rst out_valid", out_valid, 0);
    chk("mid-rst result", result, 0);
    chk("mid-rst cc", cc, 3'b100);
    chk("mid-rst in_ready", in_ready, 1);

    // WIDTH=8 instance
    in_valid8 = 1; a8 = 8'h80; b8 = 8'h01; fn8 = 2'b01; set_cc8 = 1; cond_fn = 4'd2;
    tick;
    chk("w8 sub result", result8, 8'h7F);
    chk("w8 sub carry", carry8, 0);
    chk("w8 sub cc", cc8, 3'b001);
    chk("w8 sub cnd l", cnd8, 1);
    a8 = 8'hFF; b8 = 8'h01; fn8 = 2'b00;
    tick;
    chk("w8 add result", result8, 8'h00);
    chk("w8 add carry", carry8, 1);
    chk("w8 add cc", cc8, 3'b100);
    in_valid8 = 0;
    tick;
    chk("w8 out_valid", out_valid8, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
